// File: rtl/rr_mux_n_pkg.sv
// mux_pkg: shared defaults, select-mode encodings and clog2 helper for rr_mux_n
package mux_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_N = 8;
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR = 1;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/rr_mux_n_if.sv
// rr_mux_n_if: N-channel valid/ready input bus plus registered single-channel output bus (master = producer/consumer side, slave = mux side)
interface rr_mux_n_if
    import mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N = DEF_N
);
    localparam int SEL_W = clog2(N);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0] in_valid;
    logic [N-1:0] in_ready;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] out_data;
    logic [SEL_W-1:0] out_chan;
    logic out_valid;
    logic out_ready;
    modport master (
        output in_data, in_valid, sel, out_ready,
        input in_ready, out_data, out_chan, out_valid
    );
    modport slave (
        input in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/rr_mux_n_arbiter.sv
// rr_arbiter: rotating-priority arbiter searching upward from ptr+1, ptr moves to the winner only when advance is high (ports: clk, reset, req, advance, grant, grant_idx)
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          req,
    input  logic                  advance,
    output logic [N-1:0]          grant,
    output logic [clog2(N)-1:0]   grant_idx
);
    localparam int SEL_W = clog2(N);
    logic [SEL_W-1:0] ptr;
    always_comb begin
        grant_idx = '0;
        for (int k = N; k >= 1; k--)
            if (req[(int'(ptr) + k) % N]) grant_idx = SEL_W'((int'(ptr) + k) % N);
        grant = |req ? N'(1) << grant_idx : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) ptr <= SEL_W'(N - 1);
        else if (advance) ptr <= grant_idx;
    end
endmodule

// File: rtl/rr_mux_n.sv
// rr_mux_n: N-to-1 valid/ready mux with fixed or round-robin select into a one-entry output register (ports: clk, reset, bus)
module rr_mux_n
    import mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N = DEF_N,
    parameter int MODE = MODE_RR
) (
    input logic       clk,
    input logic       reset,
    rr_mux_n_if.slave bus
);
    localparam int SEL_W = clog2(N);
    logic load_en;
    logic xfer;
    logic [N-1:0] grant;
    logic [SEL_W-1:0] grant_idx;
    assign load_en = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = reset ? '0 : grant & {N{load_en}};
    assign xfer = |bus.in_ready;
    generate
        if (MODE == MODE_RR) begin : g_rr
            rr_arbiter #(.N(N)) u_arb (
                .clk(clk),
                .reset(reset),
                .req(bus.in_valid),
                .advance(xfer),
                .grant(grant),
                .grant_idx(grant_idx)
            );
        end else begin : g_fixed
            assign grant_idx = bus.sel;
            assign grant = (int'(bus.sel) < N && bus.in_valid[bus.sel]) ? N'(1) << bus.sel : '0;
        end
    endgenerate
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
            bus.out_chan <= '0;
        end else if (load_en) begin
            bus.out_valid <= xfer;
            if (xfer) begin
                bus.out_data <= bus.in_data[grant_idx*WIDTH +: WIDTH];
                bus.out_chan <= grant_idx;
            end
        end
    end
endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n: directed and randomized checks of rr_mux_n in round-robin and fixed modes against a behavioural model
module tb_rr_mux_n;
    import mux_pkg::*;
    localparam int W = 16;
    localparam int N = 8;
    localparam int SW = clog2(N);
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    rr_mux_n_if #(.WIDTH(W), .N(N)) b1 ();
    rr_mux_n_if #(.WIDTH(W), .N(N)) b0 ();
    rr_mux_n #(.WIDTH(W), .N(N), .MODE(MODE_RR)) dut_rr (.clk(clk), .reset(reset), .bus(b1.slave));
    rr_mux_n #(.WIDTH(W), .N(N), .MODE(MODE_FIXED)) dut_fx (.clk(clk), .reset(reset), .bus(b0.slave));
    int checks = 0;
    int failures = 0;
    int p1;
    bit v1, v0;
    logic [W-1:0] d1, d0;
    int c1, c0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction
    function automatic int fx_pick(input logic [N-1:0] v, input logic [SW-1:0] s);
        return (int'(s) < N && v[s]) ? int'(s) : -1;
    endfunction
    task automatic tick();
        int g1, g0;
        bit le1, le0;
        logic [N-1:0] er1, er0;
        #1;
        le1 = !v1 || b1.out_ready;
        le0 = !v0 || b0.out_ready;
        g1 = rr_pick(b1.in_valid, p1);
        g0 = fx_pick(b0.in_valid, b0.sel);
        er1 = (reset || !le1 || g1 < 0) ? '0 : N'(1) << g1;
        er0 = (reset || !le0 || g0 < 0) ? '0 : N'(1) << g0;
        chk("rr_in_ready", b1.in_ready, er1);
        chk("fx_in_ready", b0.in_ready, er0);
        if (reset) begin
            v1 = 0; d1 = '0; c1 = 0; p1 = N - 1;
            v0 = 0; d0 = '0; c0 = 0;
        end else begin
            if (le1) begin
                v1 = g1 >= 0;
                if (g1 >= 0) begin d1 = b1.in_data[g1*W +: W]; c1 = g1; p1 = g1; end
            end
            if (le0) begin
                v0 = g0 >= 0;
                if (g0 >= 0) begin d0 = b0.in_data[g0*W +: W]; c0 = g0; end
            end
        end
        @(posedge clk);
        #1;
        chk("rr_out_valid", b1.out_valid, v1);
        chk("rr_out_data", b1.out_data, d1);
        chk("rr_out_chan", b1.out_chan, c1);
        chk("fx_out_valid", b0.out_valid, v0);
        chk("fx_out_data", b0.out_data, d0);
        chk("fx_out_chan", b0.out_chan, c0);
    endtask
    initial begin
        p1 = N - 1; v1 = 0; v0 = 0; d1 = '0; d0 = '0; c1 = 0; c0 = 0;
        reset = 1'b1;
        for (int i = 0; i < N; i++) b1.in_data[i*W +: W] = W'(16'h1000 + i);
        b1.in_valid = '1;
        b1.out_ready = 1'b1;
        b1.sel = '0;
        b0.in_data = '0;
        b0.in_valid = '0;
        b0.out_ready = 1'b1;
        b0.sel = '0;
        tick();
        tick();
        chk("reset_in_ready", b1.in_ready, 0);
        chk("reset_out_valid", b1.out_valid, 0);
        chk("reset_out_data", b1.out_data, 0);
        reset = 1'b0;
        for (int i = 0; i <= N; i++) begin
            tick();
            chk("rr_seq_chan", b1.out_chan, i % N);
            chk("rr_seq_valid", b1.out_valid, 1);
        end
        b1.in_data[3*W +: W] = 16'hBEEF;
        tick();
        tick();
        tick();
        chk("bp_load_chan", b1.out_chan, 3);
        b1.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_data", b1.out_data, 16'hBEEF);
            chk("bp_in_ready", b1.in_ready, 0);
        end
        b1.out_ready = 1'b1;
        tick();
        chk("bp_release_chan", b1.out_chan, 4);
        b1.in_valid = 8'h40;
        tick();
        chk("sparse_ptr6", b1.out_chan, 6);
        b1.in_valid = 8'h42;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("sparse_order", b1.out_chan, (i % 2 == 0) ? 1 : 6);
        end
        b1.in_valid = '0;
        b0.sel = 3'd5;
        b0.in_data[5*W +: W] = 16'h00A5;
        b0.in_data[2*W +: W] = 16'h00A2;
        b0.in_valid = 8'h24;
        #1;
        chk("fx_only_ready5", b0.in_ready, 8'h20);
        tick();
        chk("fx_data", b0.out_data, 16'h00A5);
        chk("fx_chan", b0.out_chan, 5);
        b0.in_valid = 8'h04;
        tick();
        chk("fx_drop_valid", b0.out_valid, 0);
        chk("fx_hold_data", b0.out_data, 16'h00A5);
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 39) == 0);
            b1.in_valid = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
            b0.in_valid = N'($urandom);
            b1.out_ready = $urandom_range(0, 3) != 0;
            b0.out_ready = $urandom_range(0, 2) != 0;
            b0.sel = SW'($urandom);
            for (int i = 0; i < N; i++) begin
                b1.in_data[i*W +: W] = W'($urandom);
                b0.in_data[i*W +: W] = W'($urandom);
            end
            tick();
        end
        reset = 1'b0;
        b1.in_valid = '1;
        b1.out_ready = 1'b0;
        tick();
        tick();
        chk("stall_valid", b1.out_valid, 1);
        reset = 1'b1;
        tick();
        chk("stall_reset_valid", b1.out_valid, 0);
        chk("stall_reset_data", b1.out_data, 0);
        reset = 1'b0;
        b1.out_ready = 1'b1;
        tick();
        chk("post_reset_chan", b1.out_chan, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
